q16_stack_ctrl: RTL and testbench

//  Parametrised hardware stack for the Q16 core: owns storage, pointer and error flags, replacing the address-only pointer unit.
//  Top-of-stack (TOS) held in a register; lower entries in an internal sync-read RAM. Peek is zero-latency.

---
 rtl/q16_stack_pkg.sv | 15 +
 rtl/q16_stack_ctrl_if.sv | 32 +++
 rtl/q16_stack_ram.sv | 30 +++
 rtl/q16_stack_ctrl.sv | 149 ++++++++++++++
 tb/tb_q16_stack_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/q16_stack_pkg.sv
// Shared types and width helpers for the Q16 hardware stack.
package q16_stack_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_REFILL} state_e;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // A single-entry RAM still needs a 1-bit address.
  function automatic int unsigned addr_w(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/q16_stack_ctrl_if.sv
// Decoder/datapath-facing bundle of the Q16 stack: requests in, TOS and status out.
interface q16_stack_ctrl_if import q16_stack_pkg::*; #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256
);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic              s;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic              clr_err;
  logic              ready;
  logic [DATA_W-1:0] tos_data;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              ovf;
  logic              unf;
  logic [CNT_W-1:0]  hwm;

  modport master (
    output s, push, pop, push_data, clr_err,
    input  ready, tos_data, count, empty, full, ovf, unf, hwm
  );

  modport slave (
    input  s, push, pop, push_data, clr_err,
    output ready, tos_data, count, empty, full, ovf, unf, hwm
  );

endinterface

// File: rtl/q16_stack_ram.sv
// Storage for stack entries below TOS: one write port, one read port with 1-cycle latency.
module q16_stack_ram import q16_stack_pkg::*; #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ENTRIES = 255,
  localparam int unsigned AW     = addr_w(ENTRIES)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [ENTRIES];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/q16_stack_ctrl.sv
// Q16 hardware stack: TOS register, RAM-backed lower entries, sticky error flags.
// Define STACK_WATERMARK_EN to build the high-water-mark register; otherwise hwm reads 0.
module q16_stack_ctrl import q16_stack_pkg::*; #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256
) (
  input logic              clk,
  input logic              rst,
  q16_stack_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam int unsigned AW    = addr_w(DEPTH - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] tos_q, tos_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  logic ready, req_push, req_pop, is_full, is_empty;

  assign ready    = (state_q == ST_IDLE);
  assign req_push = bus.s & ready & bus.push;
  assign req_pop  = bus.s & ready & bus.pop;
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    tos_d     = tos_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = '0;
    ram_raddr = '0;

    // Clear first so a flag raised in the same cycle wins.
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (req_push && req_pop) begin
          tos_d = bus.push_data;
          if (is_empty) begin
            count_d = CNT_W'(1);
            unf_d   = 1'b1;
          end
        end else if (req_push) begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            if (!is_empty) begin
              ram_we    = 1'b1;
              ram_waddr = AW'(count_q - CNT_W'(1));
            end
            tos_d   = bus.push_data;
            count_d = count_q + CNT_W'(1);
          end
        end else if (req_pop) begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else if (count_q == CNT_W'(1)) begin
            count_d = '0;
          end else begin
            ram_re    = 1'b1;
            ram_raddr = AW'(count_q - CNT_W'(2));
            count_d   = count_q - CNT_W'(1);
            state_d   = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        tos_d   = ram_rdata;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tos_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tos_q   <= tos_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  q16_stack_ram #(
    .DATA_W  (DATA_W),
    .ENTRIES (DEPTH - 1)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (tos_q),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

`ifdef STACK_WATERMARK_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;
  logic [CNT_W-1:0] hwm_base;

  always_comb begin
    hwm_base = bus.clr_err ? '0 : hwm_q;
    hwm_d    = (count_d > hwm_base) ? count_d : hwm_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign bus.hwm = hwm_q;
`else
  assign bus.hwm = '0;
`endif

  assign bus.ready    = ready;
  assign bus.tos_data = tos_q;
  assign bus.count    = count_q;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;

endmodule

// File: tb/tb_q16_stack_ctrl.sv
// Directed bench for q16_stack_ctrl: queue-based stack model checked every cycle plus literal pins.
module tb_q16_stack_ctrl;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  q16_stack_ctrl_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  q16_stack_ctrl #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: queue back is the top of stack.
  logic [DW-1:0] m_stk[$];
  bit            m_ovf, m_unf, m_busy;
  int            m_hwm;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_stk.delete();
      m_ovf  = 0;
      m_unf  = 0;
      m_busy = 0;
      m_hwm  = 0;
    end else begin
      if (bus.clr_err) begin
        m_ovf = 0;
        m_unf = 0;
      end
      if (m_busy) begin
        m_busy = 0;
      end else if (bus.s && (bus.push || bus.pop)) begin
        if (bus.push && bus.pop) begin
          if (m_stk.size() == 0) begin
            m_stk.push_back(bus.push_data);
            m_unf = 1;
          end else begin
            m_stk[m_stk.size()-1] = bus.push_data;
          end
        end else if (bus.push) begin
          if (m_stk.size() == DEPTH) m_ovf = 1;
          else m_stk.push_back(bus.push_data);
        end else begin
          if (m_stk.size() == 0) m_unf = 1;
          else begin
            void'(m_stk.pop_back());
            if (m_stk.size() >= 1) m_busy = 1;
          end
        end
      end
`ifdef STACK_WATERMARK_EN
      if (bus.clr_err) m_hwm = m_stk.size();
      else if (m_stk.size() > m_hwm) m_hwm = m_stk.size();
`endif
    end
  end

  always @(negedge clk) begin
    chk("count", bus.count, m_stk.size());
    chk("empty", bus.empty, m_stk.size() == 0);
    chk("full", bus.full, m_stk.size() == DEPTH);
    chk("ready", bus.ready, !m_busy);
    chk("ovf", bus.ovf, m_ovf);
    chk("unf", bus.unf, m_unf);
    chk("hwm", bus.hwm, m_hwm);
    if (!m_busy && m_stk.size() != 0) chk("tos", bus.tos_data, m_stk[m_stk.size()-1]);
  end

  task automatic cyc(input bit s, input bit pu, input bit po, input logic [DW-1:0] d,
                     input bit clr);
    bus.s         = s;
    bus.push      = pu;
    bus.pop       = po;
    bus.push_data = d;
    bus.clr_err   = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, '0, 0);
  endtask

  initial begin
    bus.s = 0; bus.push = 0; bus.pop = 0; bus.push_data = '0; bus.clr_err = 0;
    rst = 1;
    idle();
    rst = 0;
    chk("rst_count", bus.count, 0);
    chk("rst_ready", bus.ready, 1);
    chk("rst_tos", bus.tos_data, 0);
    chk("rst_flags", {bus.ovf, bus.unf}, 0);
    chk("rst_hwm", bus.hwm, 0);

    cyc(1, 1, 0, 16'h0001, 0);
    cyc(1, 1, 0, 16'h0002, 0);
    cyc(1, 1, 0, 16'h0003, 0);
    chk("push3_count", bus.count, 3);
    chk("push3_tos", bus.tos_data, 16'h0003);
    chk("push3_ready", bus.ready, 1);

    cyc(1, 0, 1, '0, 0);
    chk("pop_ready", bus.ready, 0);
    chk("pop_count", bus.count, 2);
    idle();
    chk("refill_tos", bus.tos_data, 16'h0002);
    chk("refill_ready", bus.ready, 1);

    cyc(1, 1, 0, 16'h0004, 0);
    cyc(1, 1, 0, 16'h0005, 0);
    chk("fill_full", bus.full, 1);
    cyc(1, 1, 0, 16'hBEEF, 0);
    chk("ovf_set", bus.ovf, 1);
    chk("ovf_count", bus.count, 4);
    chk("ovf_tos", bus.tos_data, 16'h0005);
    cyc(0, 0, 0, '0, 1);
    chk("ovf_clr", bus.ovf, 0);

    cyc(1, 1, 1, 16'hAAAA, 0);
    chk("repl_tos", bus.tos_data, 16'hAAAA);
    chk("repl_count", bus.count, DEPTH);
    chk("repl_ovf", bus.ovf, 0);

    cyc(0, 1, 0, 16'h0009, 0);
    chk("s_low_count", bus.count, 4);

    cyc(1, 0, 1, '0, 0);
    cyc(1, 1, 0, 16'h0077, 0);
    chk("busy_ign_count", bus.count, 3);
    chk("busy_ign_tos", bus.tos_data, 16'h0004);

    cyc(1, 0, 1, '0, 0);
    idle();
    chk("drain2_tos", bus.tos_data, 16'h0002);
    cyc(1, 0, 1, '0, 0);
    idle();
    chk("drain1_tos", bus.tos_data, 16'h0001);
    cyc(1, 0, 1, '0, 0);
    chk("drain0_count", bus.count, 0);
    chk("drain0_ready", bus.ready, 1);

    cyc(1, 0, 1, '0, 0);
    chk("unf_set", bus.unf, 1);
    chk("unf_count", bus.count, 0);
    cyc(1, 1, 1, 16'h0055, 0);
    chk("pp_empty_count", bus.count, 1);
    chk("pp_empty_tos", bus.tos_data, 16'h0055);
    chk("pp_empty_unf", bus.unf, 1);
    cyc(0, 0, 0, '0, 1);
    chk("unf_clr", bus.unf, 0);

    cyc(1, 0, 1, '0, 1);
    cyc(1, 0, 1, '0, 1);
    chk("unf_set_dom", bus.unf, 1);
    cyc(0, 0, 0, '0, 1);

    cyc(1, 1, 0, 16'h0055, 0);
    cyc(1, 1, 0, 16'h0066, 0);
    cyc(1, 0, 1, '0, 0);
    chk("pre_rst_ready", bus.ready, 0);
    rst = 1;
    idle();
    rst = 0;
    chk("rst_refill_count", bus.count, 0);
    chk("rst_refill_ready", bus.ready, 1);

    cyc(1, 1, 0, 16'h0011, 0);
    cyc(1, 1, 0, 16'h0022, 0);
    cyc(1, 1, 0, 16'h0033, 0);
    cyc(1, 0, 1, '0, 0);
    idle();
    cyc(1, 0, 1, '0, 0);
    idle();
    chk("wm_count", bus.count, 1);
    chk("wm_tos", bus.tos_data, 16'h0011);
`ifdef STACK_WATERMARK_EN
    chk("wm_hwm", bus.hwm, 3);
`else
    chk("wm_hwm", bus.hwm, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
